// File: rtl/forward_hazard_sb.sv
// -----------------------------------------------------------------------------
// forward_hazard_sb
//
// Operand forwarding and hazard unit for the integer/FP pipeline. Selects the
// EX operand source (regfile, MEM or WB) for NUM_SRC tagged operands, detects
// load-use hazards, and tracks in-flight long-latency results in a small
// scoreboard that raises RAW, WAW and occupancy stalls.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   ex_rs_addr_i/_fp_i      EX source operands (address slice k, file select)
//   mem_rd_*, mem_is_load_i MEM-stage destination, write enables, load flag
//   wb_rd_*                 WB-stage destination and write enables
//   id_rs_addr/_fp/_used_i  ID source operands and which are actually read
//   ex_rd_addr_i, ex_is_load_i, ex_rd_fp_i   EX load destination
//   issue_*                 long-latency op leaving ID (rd, file, latency)
//   fwd_sel_o               per operand: 00 regfile, 01 MEM, 10 WB
//   stall_o                 hold IF/ID, bubble EX
//   sb_full_o               every scoreboard entry is in use
//   stall_cnt_o             stall-cycle counter (only with FWD_SB_PERF_EN)
//
// Optional feature macro: FWD_SB_PERF_EN adds the saturating stall_cnt_o.
// -----------------------------------------------------------------------------
module forward_hazard_sb #(
  parameter int NUM_SRC  = 3,
  parameter int ADDR_W   = 5,
  parameter int SB_DEPTH = 4,
  parameter int LAT_W    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_rs_addr_i,
  input  logic [NUM_SRC-1:0]        ex_rs_fp_i,
  input  logic [ADDR_W-1:0]         mem_rd_addr_i,
  input  logic                      mem_rd_wren_I_i,
  input  logic                      mem_rd_wren_F_i,
  input  logic                      mem_is_load_i,
  input  logic [ADDR_W-1:0]         wb_rd_addr_i,
  input  logic                      wb_rd_wren_I_i,
  input  logic                      wb_rd_wren_F_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr_i,
  input  logic [NUM_SRC-1:0]        id_rs_fp_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [ADDR_W-1:0]         ex_rd_addr_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_rd_fp_i,
  input  logic                      issue_valid_i,
  input  logic [ADDR_W-1:0]         issue_rd_addr_i,
  input  logic                      issue_rd_fp_i,
  input  logic [LAT_W-1:0]          issue_lat_i,
  output logic [NUM_SRC*2-1:0]      fwd_sel_o,
  output logic                      stall_o,
  output logic                      sb_full_o
`ifdef FWD_SB_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              fp;
    logic [LAT_W-1:0]  cnt;
  } sb_entry_t;

  sb_entry_t           sb_q [SB_DEPTH];
  logic                load_use;
  logic                sb_stall;
  logic [SB_DEPTH-1:0] alloc_oh;

  // Same file and same address; integer x0 is hardwired and never a
  // dependency, while FP f0 is a real register.
  function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                      input logic              a_fp,
                                      input logic [ADDR_W-1:0] b,
                                      input logic              b_fp);
    return (a == b) && (a_fp == b_fp) && (a_fp || (a != '0));
  endfunction

  // Forwarding select; MEM is checked first so the younger result wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    fwd_sel_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if ((ex_rs_fp_i[k] ? mem_rd_wren_F_i : mem_rd_wren_I_i) && !mem_is_load_i &&
          addr_match(ex_rs_addr_i[k*ADDR_W +: ADDR_W], ex_rs_fp_i[k],
                     mem_rd_addr_i, ex_rs_fp_i[k])) begin
        fwd_sel_o[2*k +: 2] = 2'b01;
      end else if ((ex_rs_fp_i[k] ? wb_rd_wren_F_i : wb_rd_wren_I_i) &&
                   addr_match(ex_rs_addr_i[k*ADDR_W +: ADDR_W], ex_rs_fp_i[k],
                              wb_rd_addr_i, ex_rs_fp_i[k])) begin
        fwd_sel_o[2*k +: 2] = 2'b10;
      end
    end
  end

  // Hazard detection. All scoreboard terms come from registered state, so
  // an entry retiring this cycle still blocks until the next edge.
  always_comb begin
    load_use  = 1'b0;
    sb_stall  = 1'b0;
    sb_full_o = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ex_is_load_i && id_rs_used_i[k] &&
          addr_match(id_rs_addr_i[k*ADDR_W +: ADDR_W], id_rs_fp_i[k],
                     ex_rd_addr_i, ex_rd_fp_i)) begin
        load_use = 1'b1;
      end
    end
    for (int j = 0; j < SB_DEPTH; j++) begin
      if (!sb_q[j].valid) begin
        sb_full_o = 1'b0;
      end else begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (id_rs_used_i[k] &&
              addr_match(id_rs_addr_i[k*ADDR_W +: ADDR_W], id_rs_fp_i[k],
                         sb_q[j].rd, sb_q[j].fp)) begin
            sb_stall = 1'b1;
          end
        end
        if (issue_valid_i &&
            addr_match(issue_rd_addr_i, issue_rd_fp_i, sb_q[j].rd, sb_q[j].fp)) begin
          sb_stall = 1'b1;
        end
      end
    end
    if (issue_valid_i && sb_full_o) begin
      sb_stall = 1'b1;
    end
    stall_o = load_use | sb_stall;
  end

  // Lowest-index free entry, only when the issue is actually accepted.
  always_comb begin
    alloc_oh = '0;
    if (issue_valid_i && !stall_o) begin
      for (int j = SB_DEPTH - 1; j >= 0; j--) begin
        if (!sb_q[j].valid) begin
          alloc_oh = '0;
          alloc_oh[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the scoreboard array is reset because its valid bits are
      // control state; a stale valid after reset would stall forever.
      for (int j = 0; j < SB_DEPTH; j++) begin
        sb_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < SB_DEPTH; j++) begin
        if (sb_q[j].valid) begin
          // NOTE: non-blocking assignments keep every entry updating from
          // the same pre-edge snapshot, independent of statement order.
          sb_q[j].cnt <= sb_q[j].cnt - LAT_W'(1);
          if (sb_q[j].cnt == LAT_W'(1)) begin
            sb_q[j].valid <= 1'b0;
          end
        end else if (alloc_oh[j]) begin
          sb_q[j] <= '{valid: 1'b1, rd: issue_rd_addr_i, fp: issue_rd_fp_i,
                       cnt: issue_lat_i};
        end
      end
    end
  end

`ifdef FWD_SB_PERF_EN
  // Stall-cycle counter, saturating at all ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/forward_hazard_sb.md
Name: forward_hazard_sb

Overview:
- Parametrised next-generation operand forwarding and hazard unit for the integer/FP pipeline.
- Generalises EX-stage forwarding to NUM_SRC source operands, each tagged as integer or FP.
- Adds load-use stall detection and a small scoreboard that tracks multi-cycle FP results, with occupancy/WAW stalls.
- Sits beside the ID/EX pipeline registers; drives EX operand muxes and the ID/IF stall line.

Parameters:
- NUM_SRC, 3, number of source operands per instruction (rs1, rs2, rs3).
- ADDR_W, 5, register address width.
- SB_DEPTH, 4, scoreboard entries for in-flight long-latency ops (power of two not required, >=1).
- LAT_W, 4, width of the per-entry latency counter; max latency 2^LAT_W-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- ex_rs_addr_i  in  NUM_SRC*ADDR_W  EX source addresses; slice k = operand k.
- ex_rs_fp_i  in  NUM_SRC  1 = operand k reads the FP file.
- mem_rd_addr_i  in  ADDR_W  MEM-stage destination.
- mem_rd_wren_I_i / mem_rd_wren_F_i  in  1 each  MEM writes the int / FP file.
- mem_is_load_i  in  1  MEM instruction is a load; its data is not yet forwardable.
- wb_rd_addr_i  in  ADDR_W  WB-stage destination.
- wb_rd_wren_I_i / wb_rd_wren_F_i  in  1 each  WB writes the int / FP file.
- id_rs_addr_i  in  NUM_SRC*ADDR_W  ID source addresses.
- id_rs_fp_i  in  NUM_SRC  ID operand file select.
- id_rs_used_i  in  NUM_SRC  ID operand k is actually read.
- ex_rd_addr_i  in  ADDR_W  EX-stage destination.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_rd_fp_i  in  1  EX load target is the FP file.
- issue_valid_i  in  1  long-latency op leaving ID this cycle.
- issue_rd_addr_i  in  ADDR_W  its destination.
- issue_rd_fp_i  in  1  its destination file.
- issue_lat_i  in  LAT_W  cycles until its result is written; must be >=1.
- fwd_sel_o  out  NUM_SRC*2  per operand: 00 = regfile, 01 = MEM, 10 = WB.
- stall_o  out  1  hold IF/ID, bubble EX.
- sb_full_o  out  1  all scoreboard entries valid.

Behaviour:
- Address match means equal address AND same file. The int-file address 0 never matches; FP f0 is a real register and does match.
- fwd_sel, combinational, per operand k:
  - 01 if MEM writes the matching file, !mem_is_load_i, and addresses match.
  - else 10 if WB writes the matching file and addresses match.
  - else 00. MEM has priority over WB.
- Load-use stall (combinational): ex_is_load_i and any used ID operand matches ex_rd_addr_i/ex_rd_fp_i.
- Scoreboard: SB_DEPTH entries of {valid, rd, fp, cnt}.
  - Each cycle every valid entry decrements cnt; an entry with cnt==1 clears valid at the edge.
  - Issue allocates the lowest-index free entry with cnt=issue_lat_i.
  - An entry freed in cycle N is allocatable in cycle N+1 only, never in the same cycle.
- SB stall (combinational from registered state) when any of:
  - a used ID operand matches a valid entry (RAW);
  - issue_valid_i and issue rd/fp match a valid entry (WAW);
  - issue_valid_i and sb_full_o.
- stall_o = load-use | SB stall. While stall_o=1, issue_valid_i is ignored (no allocation); the issuer holds and retries.
- Simultaneous events: decrement-to-free and an allocation to a different entry in the same cycle are both performed.
- Reset (including mid-operation): all entries invalid and counters 0 on the next edge; sb_full_o=0; stall_o=0 unless a load-use condition is present.

Optional Feature:
- FWD_SB_PERF_EN defined: adds output stall_cnt_o[31:0].
  - Increments on every cycle with stall_o=1; saturates at 0xFFFFFFFF; cleared by rst_i.
- Undefined: the port and counter are absent.

Test Plan:
- MEM wren_I, rd=5, not load; WB wren_I, rd=5; ex rs1=5 int -> fwd_sel[1:0]=01. Set mem_is_load_i=1 -> 10.
- Int rd=0 in MEM vs rs1=0 -> 00. FP wren_F rd=0 in MEM vs rs1=f0 -> 01. Int rd=3 vs FP rs2=f3 -> 00.
- EX load to x7, ID rs2=x7 used -> stall_o=1. Same with id_rs_used_i[1]=0 -> stall_o=0.
- Issue FP f9 with lat=3; ID reads f9 next cycle -> stall_o=1 for 3 cycles, 0 on the 4th.
- Fill 4 entries (lat=15), 5th issue -> sb_full_o=1 and stall_o=1. Re-issue to a valid rd -> WAW stall. rst_i mid-run -> sb_full_o=0 and stall_o=0 next cycle.
- With FWD_SB_PERF_EN, 3-cycle RAW stall -> stall_cnt_o=3.
